fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the multi-cycle, non-pipelined MIPS datapath. Sits directly upstream of decode_unit.
- Holds the program counter and computes the next PC (sequential or branch target using the already shifted, sign-extended Immed from decode).
- Fetches from instruction memory over a req/ack handshake and holds the fetched word in the instruction register that drives decode_unit's Instr input.
- Driven one step at a time by the multi-cycle control FSM.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, max WAIT cycles before a fetch is aborted (only with FETCH_TIMEOUT_EN).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- PC_LdEn  in  1  one-cycle pulse: load next PC.
- PC_sel  in  1  0: next PC = PC+4; 1: next PC = PC+4+Immed.
- Immed  in  32  branch offset from decode_unit, already <<2 and sign-extended.
- Fetch_req  in  1  one-cycle pulse: fetch instruction at PC.
- IMem_addr  out  32  byte address to instruction memory, registered.
- IMem_req  out  1  memory request, registered.
- IMem_ack  in  1  memory acknowledge; IMem_data valid in the same cycle.
- IMem_data  in  32  instruction word from memory.
- PC  out  32  current program counter.
- Instr  out  32  instruction register, feeds decode_unit.
- Instr_valid  out  1  Instr holds a completed fetch not yet superseded.
- Busy  out  1  high in WAIT.
- Fetch_err  out  1  timeout flag (0 when feature compiled out).

Behaviour:
- Reset (async, active-high), all outputs:
  - PC = RESET_PC, IMem_addr = RESET_PC.
  - IMem_req = 0, Instr = 32'h0, Instr_valid = 0, Busy = 0, Fetch_err = 0.
  - FSM goes to IDLE.
- Reset mid-fetch: IMem_req drops immediately; any later ack is ignored.
- FSM has two states, IDLE and WAIT.
- IDLE, PC_LdEn=1: PC <= PC + 4 + (PC_sel ? Immed : 0), 32-bit modulo arithmetic. Wraps at 2^32 (32'hFFFF_FFFC + 4 = 0); no overflow flag.
- IDLE, Fetch_req=1:
  - IMem_addr <= address to fetch, IMem_req <= 1, Instr_valid <= 0, Fetch_err <= 0; go to WAIT.
  - Normally the address is the current PC.
  - If PC_LdEn and Fetch_req arrive in the same cycle, the PC update applies first and the fetch uses the new PC.
- WAIT:
  - IMem_req held high and IMem_addr held stable.
  - PC_LdEn and Fetch_req are ignored (dropped, not queued).
- WAIT with IMem_ack=1: Instr <= IMem_data, Instr_valid <= 1, IMem_req <= 0; go to IDLE.
- Latency: Fetch_req sampled at edge n, then IMem_req high after edge n. The earliest ack is sampled at edge n+1, so Instr/Instr_valid update at edge n+1 (minimum 2 cycles from the pulse to valid instruction).
- IMem_ack while in IDLE: ignored, no state change.
- Instr retains its value until the next successful fetch. Instr_valid clears when a new fetch is accepted.
- Busy = (state == WAIT).
- PC alignment is not checked; PC+4 preserves alignment and Immed is aligned by construction.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES without ack: IMem_req <= 0, Fetch_err <= 1, Instr unchanged, Instr_valid stays 0; go to IDLE.
  - Fetch_err is sticky until the next accepted Fetch_req or reset.
  - An ack in the same cycle as the timeout completes normally; ack wins.
- Not defined: no counter; WAIT lasts until ack; Fetch_err tied to 0.

Test Plan:
- Reset, then Fetch_req; memory acks the next cycle with 32'h2108_0005 -> IMem_addr=0 while req is high; Instr=32'h2108_0005 and Instr_valid=1 two cycles after the pulse; PC=0.
- PC_LdEn with PC_sel=0, three times from PC=0 -> PC=4, 8, 12; PC=32'hFFFF_FFFC then PC_LdEn -> PC=0.
- PC=32'h100, PC_sel=1, Immed=32'hFFFF_FFF0, PC_LdEn and Fetch_req in the same cycle -> PC=32'hF4 and IMem_addr=32'hF4.
- Ack delayed 5 cycles; PC_LdEn and Fetch_req pulsed during WAIT -> PC unchanged, a single request only, Busy high for 6 cycles.
- Reset asserted mid-WAIT, then a stray ack -> IMem_req=0 asynchronously, PC=RESET_PC, Instr_valid stays 0.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> IMem_req drops after 4 WAIT cycles; Fetch_err=1 until the next Fetch_req; Instr keeps its old value.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory req/ack bus between fetch_unit (master) and memory (slave).
interface fetch_unit_if;
    logic [31:0] IMem_addr;
    logic        IMem_req;
    logic        IMem_ack;
    logic [31:0] IMem_data;
    modport master (output IMem_addr, IMem_req, input IMem_ack, IMem_data);
    modport slave  (input IMem_addr, IMem_req, output IMem_ack, IMem_data);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, next-PC logic and req/ack instruction fetch into the instruction register.
// Define FETCH_TIMEOUT_EN to abort fetches after TIMEOUT_CYCLES unacked WAIT cycles.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          PC_LdEn,
    input  logic          PC_sel,
    input  logic [31:0]   Immed,
    input  logic          Fetch_req,
    fetch_unit_if.master  imem,
    output logic [31:0]   PC,
    output logic [31:0]   Instr,
    output logic          Instr_valid,
    output logic          Busy,
    output logic          Fetch_err
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, addr_q, addr_d, instr_q, instr_d, pc_next;
    logic        req_q, req_d, valid_q, valid_d;
`ifdef FETCH_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    always_comb begin
        pc_next = pc_q + 32'd4 + (PC_sel ? Immed : 32'd0);
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        req_d   = req_q;
        valid_d = valid_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        if (state_q == S_IDLE) begin
            if (PC_LdEn) pc_d = pc_next;
            // A same-cycle PC load takes effect before the fetch address is captured
            if (Fetch_req) begin
                addr_d  = PC_LdEn ? pc_next : pc_q;
                req_d   = 1'b1;
                valid_d = 1'b0;
                state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                err_d   = 1'b0;
                cnt_d   = '0;
`endif
            end
        end else if (imem.IMem_ack) begin
            instr_d = imem.IMem_data;
            valid_d = 1'b1;
            req_d   = 1'b0;
            state_d = S_IDLE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            state_d = S_IDLE;
        end else begin
            cnt_d   = cnt_q + 32'd1;
        end
`endif
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            instr_q <= 32'h0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign PC             = pc_q;
    assign imem.IMem_addr = addr_q;
    assign imem.IMem_req  = req_q;
    assign Instr          = instr_q;
    assign Instr_valid    = valid_q;
    assign Busy           = (state_q == S_WAIT);
`ifdef FETCH_TIMEOUT_EN
    assign Fetch_err      = err_q;
`else
    assign Fetch_err      = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus against a behavioural fetch model, compared every cycle.
module tb_fetch_unit;
`ifdef FETCH_TIMEOUT_EN
    localparam int TMO = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TMO = 16;
    localparam bit TO_EN = 1'b0;
`endif
    logic        Clk = 1'b0, Reset = 1'b0;
    logic        PC_LdEn = 1'b0, PC_sel = 1'b0, Fetch_req = 1'b0;
    logic [31:0] Immed = 32'h0;
    logic [31:0] PC, Instr;
    logic        Instr_valid, Busy, Fetch_err;
    int          n_cmp = 0, n_err = 0;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(TMO)) dut (
        .Clk(Clk), .Reset(Reset), .PC_LdEn(PC_LdEn), .PC_sel(PC_sel), .Immed(Immed),
        .Fetch_req(Fetch_req), .imem(bus), .PC(PC), .Instr(Instr),
        .Instr_valid(Instr_valid), .Busy(Busy), .Fetch_err(Fetch_err)
    );

    always #5 Clk = ~Clk;

    // Behavioural model: what the fetch stage must show after each edge
    logic [31:0] m_pc, m_addr, m_instr;
    logic        m_req, m_valid, m_busy, m_err;
    int          m_wait;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_pc = 0; m_addr = 0; m_instr = 0;
            m_req = 0; m_valid = 0; m_busy = 0; m_err = 0; m_wait = 0;
        end else if (!m_busy) begin
            if (PC_LdEn) m_pc = m_pc + 4 + (PC_sel ? Immed : 0);
            if (Fetch_req) begin
                m_addr = m_pc; m_req = 1; m_valid = 0; m_err = 0; m_busy = 1; m_wait = 0;
            end
        end else if (bus.IMem_ack) begin
            m_instr = bus.IMem_data; m_valid = 1; m_req = 0; m_busy = 0;
        end else begin
            m_wait = m_wait + 1;
            if (TO_EN && m_wait == TMO) begin
                m_req = 0; m_err = 1; m_busy = 0;
            end
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    always @(negedge Clk) begin
        chk("pc", PC, m_pc);
        chk("addr", bus.IMem_addr, m_addr);
        chk("req", 32'(bus.IMem_req), 32'(m_req));
        chk("instr", Instr, m_instr);
        chk("valid", 32'(Instr_valid), 32'(m_valid));
        chk("busy", 32'(Busy), 32'(m_busy));
        chk("err", 32'(Fetch_err), 32'(m_err));
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        bus.IMem_ack = 1'b0;
        bus.IMem_data = 32'h0;
        #1 Reset = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        chk("rst_pc", PC, 32'h0);
        chk("rst_req", 32'(bus.IMem_req), 32'h0);
        chk("rst_valid", 32'(Instr_valid), 32'h0);
        chk("rst_instr", Instr, 32'h0);

        Fetch_req = 1; tick(); Fetch_req = 0;
        chk("f1_req", 32'(bus.IMem_req), 32'h1);
        chk("f1_addr", bus.IMem_addr, 32'h0);
        bus.IMem_ack = 1; bus.IMem_data = 32'h2108_0005; tick(); bus.IMem_ack = 0;
        chk("f1_instr", Instr, 32'h2108_0005);
        chk("f1_valid", 32'(Instr_valid), 32'h1);
        chk("f1_pc", PC, 32'h0);

        PC_LdEn = 1; PC_sel = 0;
        tick(); chk("seq4", PC, 32'h4);
        tick(); chk("seq8", PC, 32'h8);
        tick(); chk("seq12", PC, 32'hC);
        PC_sel = 1; Immed = 32'hFFFF_FFEC; tick(); chk("to_top", PC, 32'hFFFF_FFFC);
        PC_sel = 0; tick(); chk("wrap", PC, 32'h0);
        PC_sel = 1; Immed = 32'h0000_00FC; tick(); chk("pc100", PC, 32'h100);
        Immed = 32'hFFFF_FFF0; Fetch_req = 1; tick();
        PC_LdEn = 0; Fetch_req = 0; PC_sel = 0;
        chk("br_pc", PC, 32'hF4);
        chk("br_addr", bus.IMem_addr, 32'hF4);
        bus.IMem_ack = 1; bus.IMem_data = 32'h1111_2222; tick(); bus.IMem_ack = 0;
        chk("br_instr", Instr, 32'h1111_2222);

`ifndef FETCH_TIMEOUT_EN
        begin
            int busy_cnt = 0;
            Fetch_req = 1; tick(); Fetch_req = 0;
            for (int i = 0; i < 8; i++) begin
                busy_cnt += int'(Busy);
                chk("dw_pc", PC, 32'hF4);
                chk("dw_addr", bus.IMem_addr, 32'hF4);
                PC_LdEn = (i == 1); Fetch_req = (i == 1);
                bus.IMem_ack = (i == 5); bus.IMem_data = 32'h3333_4444;
                tick();
            end
            PC_LdEn = 0; Fetch_req = 0; bus.IMem_ack = 0;
            chk("dw_busy_cycles", 32'(busy_cnt), 32'd6);
            chk("dw_instr", Instr, 32'h3333_4444);
            chk("dw_req", 32'(bus.IMem_req), 32'h0);
        end
`else
        Fetch_req = 1; tick(); Fetch_req = 0;
        for (int i = 0; i < 4; i++) begin
            chk("to_busy", 32'(Busy), 32'h1);
            tick();
        end
        chk("to_req", 32'(bus.IMem_req), 32'h0);
        chk("to_err", 32'(Fetch_err), 32'h1);
        chk("to_instr", Instr, 32'h1111_2222);
        tick(); tick();
        chk("to_sticky", 32'(Fetch_err), 32'h1);
        Fetch_req = 1; tick(); Fetch_req = 0;
        chk("to_clear", 32'(Fetch_err), 32'h0);
        bus.IMem_ack = 1; tick(); bus.IMem_ack = 0;
`endif

        Fetch_req = 1; tick(); Fetch_req = 0;
        chk("mr_req_on", 32'(bus.IMem_req), 32'h1);
        #1 Reset = 1;
        #1 chk("mr_req_async", 32'(bus.IMem_req), 32'h0);
        chk("mr_pc", PC, 32'h0);
        tick(); Reset = 0;
        bus.IMem_ack = 1; bus.IMem_data = 32'hDEAD_BEEF; tick(); bus.IMem_ack = 0;
        chk("mr_valid", 32'(Instr_valid), 32'h0);
        chk("mr_instr", Instr, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            PC_LdEn = ($urandom_range(0, 3) == 0);
            PC_sel = $urandom_range(0, 1) == 1;
            Immed = $urandom & 32'hFFFF_FFFC;
            Fetch_req = ($urandom_range(0, 2) == 0);
            bus.IMem_ack = ($urandom_range(0, 3) == 0);
            bus.IMem_data = $urandom;
            tick();
        end
        PC_LdEn = 0; Fetch_req = 0; bus.IMem_ack = 0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
